fir_mac_alu: RTL and testbench



---
 rtl/fir_mac_alu.sv | 60 ++++++
 tb/tb_fir_mac_alu.sv | 119 +++++++++++
 2 files changed

// File: rtl/fir_mac_alu.sv
// fir_mac_alu: signed 16x16 radix-4 Booth multiply feeding a 39-bit wrapping accumulator
module fir_mac_alu (
    input  logic               clk,
    input  logic               R,
    input  logic signed [15:0] X,
    input  logic signed [15:0] B,
    output logic signed [38:0] y
);
    logic [17:0] xs, x2;
    logic [16:0] bx;
    logic [17:0] mag [8];
    logic [31:0] pp [8];
    logic [31:0] s1 [4];
    logic [31:0] s2 [2];
    logic [31:0] prod, p_q, p_d;
    logic [38:0] acc_q, acc_d;

    assign xs = {{2{X[15]}}, X};
    assign x2 = {X[15], X, 1'b0};
    assign bx = {B, 1'b0};

    for (genvar g = 0; g < 8; g++) begin : g_booth
        logic [2:0] t;
        assign t = bx[2*g+2:2*g];
        assign mag[g] = (t == 3'b001 || t == 3'b010) ? xs :
                        (t == 3'b011) ? x2 :
                        (t == 3'b100) ? -x2 :
                        (t == 3'b101 || t == 3'b110) ? -xs : '0;
        assign pp[g] = {{14{mag[g][17]}}, mag[g]} << (2*g);
    end

    for (genvar g = 0; g < 4; g++) begin : g_l1
        assign s1[g] = pp[2*g] + pp[2*g+1];
    end

    for (genvar g = 0; g < 2; g++) begin : g_l2
        assign s2[g] = s1[2*g] + s1[2*g+1];
    end

    assign prod = s2[0] + s2[1];

    // next state: register the product, fold the previous product into the sum
    always_comb begin
        p_d   = prod;
        acc_d = acc_q + {{7{p_q[31]}}, p_q};
    end

    // pipeline registers; R drops any in-flight product and clears the sum
    always_ff @(posedge clk) begin
        if (R) begin
            p_q   <= '0;
            acc_q <= '0;
        end else begin
            p_q   <= p_d;
            acc_q <= acc_d;
        end
    end

    assign y = acc_q;
endmodule

// File: tb/tb_fir_mac_alu.sv
// tb_fir_mac_alu: randomized scoreboard bench for the FIR MAC datapath
module tb_fir_mac_alu;
    logic               clk = 1'b0;
    logic               R = 1'b1;
    logic signed [15:0] X = '0;
    logic signed [15:0] B = '0;
    logic signed [38:0] y;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    logic signed [38:0] exp_q [$];
    longint hist [$];

    fir_mac_alu dut (.clk(clk), .R(R), .X(X), .B(B), .y(y));

    always #5 clk = ~clk;

    // y after an edge is the sum of every product sampled since the last reset edge,
    // except the one sampled on that very edge (still in flight)
    task automatic step(input bit r, input int x, input int b);
        longint s;
        logic signed [38:0] e;
        @(negedge clk);
        R = r;
        X = 16'(x);
        B = 16'(b);
        if (r) hist.delete();
        else hist.push_back(longint'(x) * longint'(b));
        s = 0;
        for (int i = 0; i + 1 < hist.size(); i++) s += hist[i];
        e = s[38:0];
        exp_q.push_back(e);
    endtask

    task automatic check_y(input string name, input logic signed [38:0] e);
        @(posedge clk);
        #1;
        checks++;
        if (y !== e) begin
            errors++;
            $display("FAIL %s: y=%0d expected %0d", name, y, e);
        end
    endtask

    // monitor: the DUT presents y after every edge; compare against the scoreboard
    initial begin
        logic signed [38:0] e;
        forever begin
            @(posedge clk);
            #1;
            edge_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (y !== e) begin
                    errors++;
                    $display("FAIL scoreboard edge %0d: y=%0d expected %0d", edge_no, y, e);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        step(1, 2, 1);
        step(1, 2, 1);
        check_y("reset_hold", 39'sd0);
        for (int i = 0; i < 4; i++) step(0, 2, 1);
        check_y("count_2_4_6", 39'sd6);

        step(1, 0, 0);
        step(0, -50, -50);
        step(0, -50, 49);
        step(0, 0, 0);
        check_y("neg_pair", 39'sd50);

        step(1, 0, 0);
        for (int i = 0; i < 1000; i++)
            step(0, int'($urandom_range(99)) - 50, int'($urandom_range(99)) - 50);

        step(1, 0, 0);
        for (int i = 0; i < 128; i++) step(0, -32768, -32768);
        step(0, 0, 0);
        check_y("max_128", 39'sd137438953472);
        for (int i = 0; i < 128; i++) step(0, -32768, -32768);
        step(0, 0, 0);
        check_y("wrap_256", -39'sd274877906944);

        step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 100, 7);
        step(1, 9, 9);
        check_y("midrun_reset", 39'sd0);
        for (int i = 0; i < 3; i++) step(0, 1, 1);
        check_y("resume_count", 39'sd2);

        step(1, 0, 0);
        step(0, 32767, -32768);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        check_y("extreme_hold", -39'sd1073709056);

        for (int i = 0; i < 3; i++) step(0, int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected values left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
